// File: rtl/pipe_hazard_sched_if.sv
// pipe_hazard_sched_if: datapath-facing hazard/MDU bus; STALL_CNT_EN adds the stall counters
interface pipe_hazard_sched_if #(parameter int CNT_W = 4);
  logic [4:0] rs_D, rt_D, Dst_E, Dst_M;
  logic [1:0] tuse_rs_D, tuse_rt_D, Tnew_E, Tnew_M;
  logic md_use_D, RegWrite_E, RegWrite_M, md_start_E, md_is_div_E;
  logic en_PC, en_FD, flush_DE, md_busy, md_done, md_err;
  logic [CNT_W-1:0] md_cnt;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif
  modport master(
`ifdef STALL_CNT_EN
    input stall_cnt, md_stall_cnt,
`endif
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D, RegWrite_E, Dst_E, Tnew_E,
           RegWrite_M, Dst_M, Tnew_M, md_start_E, md_is_div_E,
    input en_PC, en_FD, flush_DE, md_busy, md_done, md_cnt, md_err);
  modport slave(
`ifdef STALL_CNT_EN
    output stall_cnt, md_stall_cnt,
`endif
    input rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D, RegWrite_E, Dst_E, Tnew_E,
          RegWrite_M, Dst_M, Tnew_M, md_start_E, md_is_div_E,
    output en_PC, en_FD, flush_DE, md_busy, md_done, md_cnt, md_err);
endinterface

// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: Tuse/Tnew RAW stall detection plus mult/div busy sequencer.
// Optional STALL_CNT_EN adds stall_cnt/md_stall_cnt performance counters.
module pipe_hazard_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input logic clk,
  input logic reset,
  pipe_hazard_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);
  state_t state;
  logic [CNT_W-1:0] cnt, ld;
  logic err, hz_rs, hz_rt, md_stall, stall;
  function automatic logic hz(input logic [4:0] r, input logic [1:0] t);
    return r != 5'd0 && t != 2'd3 &&
      ((bus.RegWrite_E && bus.Dst_E == r && bus.Tnew_E > t) ||
       (bus.RegWrite_M && bus.Dst_M == r && bus.Tnew_M > t));
  endfunction
  always_comb begin
    hz_rs = hz(bus.rs_D, bus.tuse_rs_D);
    hz_rt = hz(bus.rt_D, bus.tuse_rt_D);
    md_stall = bus.md_use_D && (state == BUSY || bus.md_start_E);
    stall = reset && (hz_rs || hz_rt || md_stall);
    ld = bus.md_is_div_E ? DIV_LD : MULT_LD;
  end
  assign bus.en_PC = ~stall;
  assign bus.en_FD = ~stall;
  assign bus.flush_DE = stall;
  assign bus.md_busy = state == BUSY;
  assign bus.md_done = state == DONE;
  assign bus.md_cnt = cnt;
  assign bus.md_err = err;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.md_start_E) begin
          state <= BUSY;
          cnt <= ld;
        end
        BUSY: begin
          if (bus.md_start_E) err <= 1'b1;
          if (cnt == '0) state <= DONE;
          else cnt <= cnt - 1'b1;
        end
        DONE: begin
          state <= bus.md_start_E ? BUSY : IDLE;
          cnt <= bus.md_start_E ? ld : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.stall_cnt <= '0;
      bus.md_stall_cnt <= '0;
    end else begin
      bus.stall_cnt <= bus.stall_cnt + {31'd0, stall};
      bus.md_stall_cnt <= bus.md_stall_cnt + {31'd0, md_stall};
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_sched.sv
// tb_pipe_hazard_sched: directed checks of RAW stalls, MDU sequencing, reset abort and md_err
module tb_pipe_hazard_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  pipe_hazard_sched_if #(.CNT_W(4)) bus ();
  pipe_hazard_sched #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.rs_D = 0; bus.rt_D = 0; bus.tuse_rs_D = 2'd3; bus.tuse_rt_D = 2'd3;
    bus.md_use_D = 0; bus.RegWrite_E = 0; bus.Dst_E = 0; bus.Tnew_E = 0;
    bus.RegWrite_M = 0; bus.Dst_M = 0; bus.Tnew_M = 0;
    bus.md_start_E = 0; bus.md_is_div_E = 0;
  endtask

  task automatic test_reset();
    clr();
    reset = 0;
    bus.md_use_D = 1; bus.md_start_E = 1;
    bus.RegWrite_E = 1; bus.Dst_E = 5'd1; bus.Tnew_E = 2'd2; bus.rs_D = 5'd1; bus.tuse_rs_D = 2'd0;
    step(); step();
    #1;
    n_checks++; if (bus.en_PC !== 1'b1 || bus.en_FD !== 1'b1 || bus.flush_DE !== 1'b0) begin n_fail++; $display("FAIL reset_enables got en_PC=%b en_FD=%b flush=%b want 1 1 0", bus.en_PC, bus.en_FD, bus.flush_DE); end
    n_checks++; if ({bus.md_busy, bus.md_done, bus.md_err} !== 3'b000 || bus.md_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_state got busy=%b done=%b err=%b cnt=%0d want 0 0 0 0", bus.md_busy, bus.md_done, bus.md_err, bus.md_cnt); end
    clr();
    reset = 1;
    step();
  endtask

  task automatic test_raw();
    clr();
    bus.RegWrite_E = 1; bus.Dst_E = 5'd1; bus.Tnew_E = 2'd2; bus.rs_D = 5'd1; bus.tuse_rs_D = 2'd1;
    #1;
    n_checks++; if ({bus.en_PC, bus.en_FD, bus.flush_DE} !== 3'b001) begin n_fail++; $display("FAIL raw_e_stall got %b want 001", {bus.en_PC, bus.en_FD, bus.flush_DE}); end
    step();
    bus.RegWrite_E = 0; bus.Dst_E = 0; bus.Tnew_E = 0;
    bus.RegWrite_M = 1; bus.Dst_M = 5'd1; bus.Tnew_M = 2'd1;
    #1;
    n_checks++; if ({bus.en_PC, bus.flush_DE} !== 2'b10) begin n_fail++; $display("FAIL raw_m_release got %b want 10", {bus.en_PC, bus.flush_DE}); end
    clr();
    bus.RegWrite_M = 1; bus.Dst_M = 5'd3; bus.Tnew_M = 2'd1; bus.rt_D = 5'd3; bus.tuse_rt_D = 2'd0;
    #1;
    n_checks++; if (bus.flush_DE !== 1'b1 || bus.en_FD !== 1'b0) begin n_fail++; $display("FAIL raw_m_rt got flush=%b en_FD=%b want 1 0", bus.flush_DE, bus.en_FD); end
    clr();
    bus.RegWrite_E = 1; bus.Dst_E = 5'd7; bus.Tnew_E = 2'd2; bus.rs_D = 5'd7; bus.tuse_rs_D = 2'd3;
    #1;
    n_checks++; if (bus.flush_DE !== 1'b0) begin n_fail++; $display("FAIL raw_not_read got flush=%b want 0", bus.flush_DE); end
    bus.tuse_rs_D = 2'd2;
    #1;
    n_checks++; if (bus.flush_DE !== 1'b0) begin n_fail++; $display("FAIL raw_tnew_eq_tuse got flush=%b want 0", bus.flush_DE); end
    bus.RegWrite_E = 0; bus.tuse_rs_D = 2'd0;
    #1;
    n_checks++; if (bus.flush_DE !== 1'b0) begin n_fail++; $display("FAIL raw_no_regwrite got flush=%b want 0", bus.flush_DE); end
    step();
  endtask

  task automatic test_zero_reg();
    clr();
    bus.RegWrite_E = 1; bus.Dst_E = 5'd0; bus.Tnew_E = 2'd2; bus.rs_D = 5'd0; bus.tuse_rs_D = 2'd0;
    #1;
    n_checks++; if ({bus.en_PC, bus.flush_DE} !== 2'b10) begin n_fail++; $display("FAIL zero_reg got %b want 10", {bus.en_PC, bus.flush_DE}); end
    step();
    clr();
  endtask

  task automatic test_mult();
    int stalls = 0;
    clr();
    bus.md_start_E = 1; bus.md_is_div_E = 0; bus.md_use_D = 1;
    #1;
    n_checks++; if (bus.flush_DE !== 1'b1) begin n_fail++; $display("FAIL mult_start_stall got flush=%b want 1", bus.flush_DE); end
    if (bus.flush_DE) stalls++;
    step();
    bus.md_start_E = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (bus.md_busy !== 1'b1 || bus.md_cnt !== 4'(4 - i) || bus.md_done !== 1'b0) begin n_fail++; $display("FAIL mult_busy[%0d] got busy=%b cnt=%0d done=%b want 1 %0d 0", i, bus.md_busy, bus.md_cnt, bus.md_done, 4 - i); end
      if (bus.flush_DE) stalls++;
      step();
    end
    #1;
    n_checks++; if (bus.md_done !== 1'b1 || bus.md_busy !== 1'b0 || bus.en_PC !== 1'b1) begin n_fail++; $display("FAIL mult_done got done=%b busy=%b en_PC=%b want 1 0 1", bus.md_done, bus.md_busy, bus.en_PC); end
    n_checks++; if (stalls !== 6) begin n_fail++; $display("FAIL mult_stall_total got %0d want 6", stalls); end
    step();
    clr();
    #1;
    n_checks++; if (bus.md_done !== 1'b0 || bus.md_cnt !== 4'd0) begin n_fail++; $display("FAIL mult_idle got done=%b cnt=%0d want 0 0", bus.md_done, bus.md_cnt); end
  endtask

  task automatic test_back_to_back();
    clr();
    bus.md_start_E = 1; bus.md_is_div_E = 1;
    step();
    bus.md_start_E = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) begin
        #1;
        n_checks++; if (bus.md_busy !== 1'b1 || bus.md_cnt !== 4'(9 - i)) begin n_fail++; $display("FAIL div_busy[%0d][%0d] got busy=%b cnt=%0d want 1 %0d", r, i, bus.md_busy, bus.md_cnt, 9 - i); end
        step();
      end
      #1;
      n_checks++; if (bus.md_done !== 1'b1 || bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL div_done[%0d] got done=%b busy=%b want 1 0", r, bus.md_done, bus.md_busy); end
      bus.md_start_E = (r == 0); bus.md_is_div_E = 1;
      step();
      bus.md_start_E = 0;
    end
    #1;
    n_checks++; if (bus.md_err !== 1'b0 || bus.md_busy !== 1'b0 || bus.md_done !== 1'b0) begin n_fail++; $display("FAIL b2b_end got err=%b busy=%b done=%b want 0 0 0", bus.md_err, bus.md_busy, bus.md_done); end
  endtask

  task automatic test_abort();
    logic saw_done = 0;
    clr();
    bus.md_start_E = 1; bus.md_is_div_E = 1;
    step();
    bus.md_start_E = 0;
    step(); step(); step();
    #1;
    n_checks++; if (bus.md_cnt !== 4'd6 || bus.md_busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre got cnt=%0d busy=%b want 6 1", bus.md_cnt, bus.md_busy); end
    reset = 0; bus.md_use_D = 1;
    #1;
    n_checks++; if (bus.en_PC !== 1'b1 || bus.flush_DE !== 1'b0) begin n_fail++; $display("FAIL abort_in_reset got en_PC=%b flush=%b want 1 0", bus.en_PC, bus.flush_DE); end
    step();
    reset = 1; bus.md_use_D = 0;
    #1;
    n_checks++; if (bus.md_busy !== 1'b0 || bus.md_cnt !== 4'd0 || bus.en_PC !== 1'b1) begin n_fail++; $display("FAIL abort_post got busy=%b cnt=%0d en_PC=%b want 0 0 1", bus.md_busy, bus.md_cnt, bus.en_PC); end
    for (int i = 0; i < 12; i++) begin
      if (bus.md_done || bus.md_busy) saw_done = 1;
      step();
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got activity=%b want 0", saw_done); end
  endtask

  task automatic test_err();
    clr();
    bus.md_start_E = 1; bus.md_is_div_E = 0;
    step();
    bus.md_start_E = 0;
    step();
    bus.md_start_E = 1; bus.md_is_div_E = 1;
    step();
    bus.md_start_E = 0;
    #1;
    n_checks++; if (bus.md_err !== 1'b1 || bus.md_cnt !== 4'd2 || bus.md_busy !== 1'b1) begin n_fail++; $display("FAIL err_set got err=%b cnt=%0d busy=%b want 1 2 1", bus.md_err, bus.md_cnt, bus.md_busy); end
    step(); step(); step();
    #1;
    n_checks++; if (bus.md_done !== 1'b1) begin n_fail++; $display("FAIL err_done got done=%b want 1", bus.md_done); end
    step(); step();
    #1;
    n_checks++; if (bus.md_err !== 1'b1 || bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL err_sticky got err=%b busy=%b want 1 0", bus.md_err, bus.md_busy); end
    reset = 0;
    step();
    reset = 1;
    #1;
    n_checks++; if (bus.md_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got err=%b want 0", bus.md_err); end
  endtask

`ifdef STALL_CNT_EN
  task automatic test_stall_cnt();
    clr();
    reset = 0;
    step();
    reset = 1;
    bus.RegWrite_E = 1; bus.Dst_E = 5'd4; bus.Tnew_E = 2'd2; bus.rs_D = 5'd4; bus.tuse_rs_D = 2'd0;
    step(); step(); step();
    clr();
    step(); step();
    n_checks++; if (bus.stall_cnt !== 32'd3 || bus.md_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_raw got %0d %0d want 3 0", bus.stall_cnt, bus.md_stall_cnt); end
    bus.md_start_E = 1; bus.md_use_D = 1;
    step();
    bus.md_start_E = 0;
    for (int i = 0; i < 5; i++) step();
    bus.md_use_D = 0;
    step();
    n_checks++; if (bus.stall_cnt !== 32'd9 || bus.md_stall_cnt !== 32'd6) begin n_fail++; $display("FAIL cnt_md got %0d %0d want 9 6", bus.stall_cnt, bus.md_stall_cnt); end
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_raw();
    test_zero_reg();
    test_mult();
    test_back_to_back();
    test_abort();
    test_err();
`ifdef STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
